// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing core for the display path.
// Fetch-side counters issue the next pixel coordinates LAT clocks ahead of the
// sync / data-enable / colour outputs. A LAT-deep flag pipeline delays the
// outputs so that framebuffer read data lines up with them exactly.
// Optional build macro: VGA_TIMING_TEST_PATTERN_EN adds the pattern_en input
// and an internal 8-bar colour pattern generator.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BACK   = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 4,
    parameter int LAT      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic            pattern_en,
`endif
    input  logic [3*CW-1:0] color_in,
    output logic [11:0]     next_x,
    output logic [11:0]     next_y,
    output logic            next_valid,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue,
    output logic            frame_start,
    output logic            line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FRONT + V_PULSE);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    // Bit positions inside the delayed flag word
    localparam int F_HP = 4;
    localparam int F_VP = 3;
    localparam int F_DE = 2;
    localparam int F_FS = 1;
    localparam int F_LS = 0;

    // Reject mode parameters that cannot produce a valid raster
    if (H_FRONT == 0 || H_PULSE == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_PULSE == 0 || V_BACK == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and pulse widths must be non-zero");
    end
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("vga_timing_gen: LAT must be in 1..8");
    end

    logic [11:0]     h_cnt_q, h_cnt_d;
    logic [11:0]     v_cnt_q, v_cnt_d;
    logic            h_active_s, v_active_s;
    logic            h_pulse_s, v_pulse_s;
    logic [4:0]      raw_s;
    logic [4:0]      pipe_q [LAT];
    logic            last_in_de_s;
    logic [11:0]     next_x_s;
    logic [3*CW-1:0] color_q, color_d;

    // Next raster position: h wraps at end of line, v advances on each wrap
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 12'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 12'd0;
            end else begin
                v_cnt_d = v_cnt_q + 12'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
        end
    end

    // Fetch-side raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_active_s = (h_cnt_q < H_ACT_END);
    assign v_active_s = (v_cnt_q < V_ACT_END);
    assign h_pulse_s  = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    assign v_pulse_s  = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);

    assign next_valid = h_active_s && v_active_s;
    assign next_x_s   = next_valid ? h_cnt_q : 12'd0;
    assign next_x     = next_x_s;
    assign next_y     = v_active_s ? v_cnt_q : 12'd0;

    assign raw_s[F_HP] = h_pulse_s;
    assign raw_s[F_VP] = v_pulse_s;
    assign raw_s[F_DE] = next_valid;
    assign raw_s[F_FS] = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    assign raw_s[F_LS] = (h_cnt_q == 12'd0) && v_active_s;

    // Delay the raw raster flags by LAT clocks to meet the fetched colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_q[k] <= 5'd0;
            end
        end else begin
            pipe_q[0] <= raw_s;
            for (int k = 1; k < LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // de value about to be loaded into the output stage
    if (LAT == 1) begin : g_de_direct
        assign last_in_de_s = raw_s[F_DE];
    end else begin : g_de_pipe
        assign last_in_de_s = pipe_q[LAT-2][F_DE];
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [11:0]     bar_x_s;
    logic [11:0]     bar_full_s;
    logic [2:0]      bar_s;
    logic [3*CW-1:0] pattern_s;

    // Column delayed to the same stage as the de being loaded
    if (LAT == 1) begin : g_x_direct
        assign bar_x_s = next_x_s;
    end else begin : g_x_pipe
        logic [11:0] x_pipe_q [LAT-1];

        // Carry the requested column down toward the colour register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < LAT - 1; k++) begin
                    x_pipe_q[k] <= 12'd0;
                end
            end else begin
                x_pipe_q[0] <= next_x_s;
                for (int k = 1; k < LAT - 1; k++) begin
                    x_pipe_q[k] <= x_pipe_q[k-1];
                end
            end
        end

        assign bar_x_s = x_pipe_q[LAT-2];
    end

    assign bar_full_s = bar_x_s / 12'(BAR_W);
    assign bar_s      = (bar_full_s > 12'd7) ? 3'd7 : bar_full_s[2:0];
    assign pattern_s  = {{CW{bar_s[2]}}, {CW{bar_s[1]}}, {CW{bar_s[0]}}};
`endif

    // Colour source select, blanked whenever the loaded de is low
    always_comb begin
        color_d = '0;
        if (last_in_de_s) begin
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (pattern_en) begin
                color_d = pattern_s;
            end else begin
                color_d = color_in;
            end
`else
            color_d = color_in;
`endif
        end else begin
            color_d = '0;
        end
    end

    // Colour output register, loaded on the same edge as de
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
        end else begin
            color_q <= color_d;
        end
    end

    // Pulse flags map to the configured polarity; idle level is the complement
    assign hsync       = pipe_q[LAT-1][F_HP] ^ ~H_POL;
    assign vsync       = pipe_q[LAT-1][F_VP] ^ ~V_POL;
    assign de          = pipe_q[LAT-1][F_DE];
    assign frame_start = pipe_q[LAT-1][F_FS];
    assign line_start  = pipe_q[LAT-1][F_LS];
    assign red         = color_q[3*CW-1:2*CW];
    assign green       = color_q[2*CW-1:CW];
    assign blue        = color_q[CW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in the small 8/2/3/2 x 4/1/1/1 mode
// (15 x 7 = 105 clocks per frame). Instances: a = LAT 1 active-low syncs,
// b = LAT 3, c = LAT 1 active-high syncs, p = 16-wide test-pattern mode
// (only when VGA_TIMING_TEST_PATTERN_EN is defined).
module tb_vga_timing_gen;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic [11:0] next_x_a, next_y_a, next_x_b, next_y_b, next_x_c, next_y_c;
    logic        next_valid_a, next_valid_b, next_valid_c;
    logic        hsync_a, vsync_a, de_a, fs_a, ls_a;
    logic        hsync_b, vsync_b, de_b, fs_b, ls_b;
    logic        hsync_c, vsync_c, de_c, fs_c, ls_c;
    logic [CW-1:0] red_a, green_a, blue_a, red_b, green_b, blue_b, red_c, green_c, blue_c;
    logic [3*CW-1:0] color_a, color_b;
    logic [3:0]  xd1 = 4'h0;
    logic [3:0]  xd2 = 4'h0;

    assign color_a = {next_x_a[3:0], ~next_x_a[3:0], 4'h5};
    assign color_b = {xd2, 8'h00};

    // Two-cycle delay of the requested column, modelling a slow framebuffer
    always @(posedge clk) begin
        xd1 <= next_x_b[3:0];
        xd2 <= xd1;
    end

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(CW), .LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .pattern_en(1'b0),
`endif
        .color_in(color_a), .next_x(next_x_a), .next_y(next_y_a), .next_valid(next_valid_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .red(red_a), .green(green_a), .blue(blue_a),
        .frame_start(fs_a), .line_start(ls_a));

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(CW), .LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .pattern_en(1'b0),
`endif
        .color_in(color_b), .next_x(next_x_b), .next_y(next_y_b), .next_valid(next_valid_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .red(red_b), .green(green_b), .blue(blue_b),
        .frame_start(fs_b), .line_start(ls_b));

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(CW), .LAT(1)) u_c (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .pattern_en(1'b0),
`endif
        .color_in(color_a), .next_x(next_x_c), .next_y(next_y_c), .next_valid(next_valid_c),
        .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .red(red_c), .green(green_c), .blue(blue_c),
        .frame_start(fs_c), .line_start(ls_c));

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0] next_x_p, next_y_p;
    logic        next_valid_p, hsync_p, vsync_p, de_p, fs_p, ls_p;
    logic [CW-1:0] red_p, green_p, blue_p;

    vga_timing_gen #(.H_ACTIVE(16), .H_FRONT(2), .H_PULSE(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(1), .V_BACK(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(CW), .LAT(2)) u_p (
        .clk(clk), .rst_n(rst_n), .pattern_en(1'b1),
        .color_in(12'hABC), .next_x(next_x_p), .next_y(next_y_p), .next_valid(next_valid_p),
        .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .red(red_p), .green(green_p), .blue(blue_p),
        .frame_start(fs_p), .line_start(ls_p));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Values every instance must show while rst_n is low
    task automatic check_reset();
        check("rst_a_hs", 32'(hsync_a), 32'd1);
        check("rst_a_vs", 32'(vsync_a), 32'd1);
        check("rst_a_de", 32'(de_a), 32'd0);
        check("rst_a_rgb", 32'({red_a, green_a, blue_a}), 32'd0);
        check("rst_a_fs", 32'(fs_a), 32'd0);
        check("rst_a_ls", 32'(ls_a), 32'd0);
        check("rst_a_nvalid", 32'(next_valid_a), 32'd1);
        check("rst_a_nx", 32'(next_x_a), 32'd0);
        check("rst_a_ny", 32'(next_y_a), 32'd0);
        check("rst_b_hs", 32'(hsync_b), 32'd1);
        check("rst_b_de", 32'(de_b), 32'd0);
        check("rst_b_red", 32'(red_b), 32'd0);
        check("rst_c_hs", 32'(hsync_c), 32'd0);
        check("rst_c_vs", 32'(vsync_c), 32'd0);
        check("rst_c_de", 32'(de_c), 32'd0);
    endtask

    // Model of every instance n clock edges after reset release
    task automatic check_cycle(input int n);
        int  p, h, v, bar;
        bit  vis, hp, vp, f, l;
        // fetch side, instance a
        h = n % 15;
        v = (n / 15) % 7;
        vis = (h < 8) && (v < 4);
        check("a_nvalid", 32'(next_valid_a), 32'(vis));
        check("a_nx", 32'(next_x_a), vis ? 32'(h) : 32'd0);
        check("a_ny", 32'(next_y_a), (v < 4) ? 32'(v) : 32'd0);
        check("b_nx", 32'(next_x_b), vis ? 32'(h) : 32'd0);
        // LAT=1 output side, instances a and c
        p = n - 1;
        h = (p < 0) ? 0 : p % 15;
        v = (p < 0) ? 0 : (p / 15) % 7;
        vis = (p >= 0) && (h < 8) && (v < 4);
        hp  = (p >= 0) && (h >= 10) && (h < 13);
        vp  = (p >= 0) && (v == 5);
        f   = (p >= 0) && (p % 105 == 0);
        l   = (p >= 0) && (h == 0) && (v < 4);
        check("a_hs", 32'(hsync_a), 32'(!hp));
        check("a_vs", 32'(vsync_a), 32'(!vp));
        check("a_de", 32'(de_a), 32'(vis));
        check("a_fs", 32'(fs_a), 32'(f));
        check("a_ls", 32'(ls_a), 32'(l));
        check("a_red", 32'(red_a), vis ? 32'(h % 16) : 32'd0);
        check("a_green", 32'(green_a), vis ? 32'(15 - (h % 16)) : 32'd0);
        check("a_blue", 32'(blue_a), vis ? 32'd5 : 32'd0);
        check("c_hs", 32'(hsync_c), 32'(hp));
        check("c_vs", 32'(vsync_c), 32'(vp));
        check("c_de", 32'(de_c), 32'(vis));
        check("c_red", 32'(red_c), vis ? 32'(h % 16) : 32'd0);
        // LAT=3 output side, instance b
        p = n - 3;
        h = (p < 0) ? 0 : p % 15;
        v = (p < 0) ? 0 : (p / 15) % 7;
        vis = (p >= 0) && (h < 8) && (v < 4);
        hp  = (p >= 0) && (h >= 10) && (h < 13);
        vp  = (p >= 0) && (v == 5);
        f   = (p >= 0) && (p % 105 == 0);
        l   = (p >= 0) && (h == 0) && (v < 4);
        check("b_hs", 32'(hsync_b), 32'(!hp));
        check("b_vs", 32'(vsync_b), 32'(!vp));
        check("b_de", 32'(de_b), 32'(vis));
        check("b_fs", 32'(fs_b), 32'(f));
        check("b_ls", 32'(ls_b), 32'(l));
        check("b_red", 32'(red_b), vis ? 32'(h % 16) : 32'd0);
        check("b_gb", 32'({green_b, blue_b}), 32'd0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        // LAT=2, 23-clock lines, 2-pixel bars
        p = n - 2;
        h = (p < 0) ? 0 : p % 23;
        v = (p < 0) ? 0 : (p / 23) % 7;
        vis = (p >= 0) && (h < 16) && (v < 4);
        bar = h / 2;
        check("p_de", 32'(de_p), 32'(vis));
        check("p_red", 32'(red_p), (vis && (bar & 4) != 0) ? 32'd15 : 32'd0);
        check("p_green", 32'(green_p), (vis && (bar & 2) != 0) ? 32'd15 : 32'd0);
        check("p_blue", 32'(blue_p), (vis && (bar & 1) != 0) ? 32'd15 : 32'd0);
`endif
    endtask

    initial begin
        int de_cnt, hs_low, vs_low, ls_cnt, fs_cnt, first_fs_a, first_fs_b;
        de_cnt = 0; hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        first_fs_a = -1; first_fs_b = -1;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();

        // Release and run two frames plus 35 clocks (fetch ends at v=2, h=5)
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cycle(0);
        for (int n = 1; n <= 245; n++) begin
            @(posedge clk);
            #1;
            check_cycle(n);
            if (n <= 105) begin
                de_cnt += int'(de_a);
                hs_low += int'(!hsync_a);
                vs_low += int'(!vsync_a);
                ls_cnt += int'(ls_a);
            end
            if (n <= 210) fs_cnt += int'(fs_a);
        end
        check("a_de_per_frame", 32'(de_cnt), 32'd32);
        check("a_hs_low_per_frame", 32'(hs_low), 32'd21);
        check("a_vs_low_per_frame", 32'(vs_low), 32'd15);
        check("a_ls_per_frame", 32'(ls_cnt), 32'd4);
        check("a_fs_two_frames", 32'(fs_cnt), 32'd2);
        check("a_fetch_v_mid", 32'(next_y_a), 32'd2);
        check("a_fetch_h_mid", 32'(next_x_a), 32'd5);

        // Mid-frame asynchronous reset: outputs drop without a clock edge
        rst_n = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cycle(0);
        for (int n = 1; n <= 110; n++) begin
            @(posedge clk);
            #1;
            check_cycle(n);
            if (fs_a && first_fs_a < 0) first_fs_a = n;
            if (fs_b && first_fs_b < 0) first_fs_b = n;
        end
        check("a_fs_after_rst", 32'(first_fs_a), 32'd1);
        check("b_fs_after_rst", 32'(first_fs_b), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 VGA driver, and the video timing core for the display path. It generates hsync/vsync/data-enable for any mode given by its four horizontal and four vertical timing parameters, with programmable sync polarity and colour depth. It issues next-pixel coordinates a configurable number of cycles ahead, so framebuffers with multi-cycle read latency line up exactly with the sync outputs. It also provides frame and line start strobes for DMA and vblank logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_PULSE, 96, hsync width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_PULSE, 2, vsync width in lines
- V_BACK, 33, vertical back porch in lines
- H_POL, 0, hsync level while asserted (0 = active-low)
- V_POL, 0, vsync level while asserted
- CW, 4, bits per colour channel
- LAT, 1, pixel fetch latency in clocks (1..8)
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- color_in  in  3*CW  {R,G,B} for the pixel requested LAT-1 cycles earlier
- next_x  out  12  column being requested (0 when next_valid=0)
- next_y  out  12  row being requested (0 when not in an active line)
- next_valid  out  1  request is for a visible pixel
- hsync, vsync  out  1 each  sync outputs at the configured polarity
- de  out  1  visible pixel on the colour outputs
- red, green, blue  out  CW each  colour, forced to 0 when de=0
- frame_start  out  1  one-clock pulse on the output side with pixel (0,0)
- line_start  out  1  one-clock pulse with pixel (0,y) of every visible line

## Operation
- Internal counters run at fetch time.
  - h_cnt wraps 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_PULSE+H_BACK.
  - v_cnt increments when h_cnt wraps and wraps 0..V_TOTAL-1 (V_TOTAL defined the same way).
- Horizontal regions by h_cnt: active [0,H_ACTIVE), front porch, pulse, back porch, in that order. Vertical regions by v_cnt are ordered the same way.
- next_valid = h_active & v_active. next_x = h_cnt when next_valid, else 0. next_y = v_cnt when v_active, else 0.
- {hsync_raw, vsync_raw, de_raw, fs_raw, ls_raw} pass through a LAT-deep shift register to the outputs. Conditions for the raw strobes:
  - fs_raw: h_cnt==0 & v_cnt==0.
  - ls_raw: h_cnt==0 & v_active.
- Colour output is registered from color_in on the same edge that de is loaded. If the loaded de is 0, the colour registers load 0.
- Sync output = the configured polarity when in the pulse region, else its complement.
- Reset (asynchronous, any time, including mid-frame):
  - h_cnt=0, v_cnt=0, all shift stages cleared.
  - hsync=~H_POL, vsync=~V_POL; de, colours, frame_start and line_start all 0.
  - First cycle after release: next_valid=1, next_x=0, next_y=0.
- Invalid parameters are an elaboration error:
  - any porch or pulse value of 0;
  - H_TOTAL or V_TOTAL above 4096;
  - LAT outside 1..8.

## Timing
- Latency: the request at cycle t (next_x, next_y) produces de, sync and colour at t+LAT. color_in is sampled at the end of cycle t+LAT-1.
  - LAT=1: combinational source, colour registered one clock later.
- Frame period = H_TOTAL*V_TOTAL clocks. The hsync pulse is exactly H_PULSE clocks. vsync is exactly V_PULSE*H_TOTAL clocks and changes on the same output cycle in which the horizontal count returns to 0.
- frame_start and line_start coincide on pixel (0,0).
- line_start never fires during vertical blanking.
- Output-side signals are not valid for the first LAT cycles after reset release. They hold their reset values during that time, and no spurious sync pulse is emitted.

## Configuration
- Macro VGA_TIMING_TEST_PATTERN_EN.
  - Defined: adds input pattern_en (1 bit). When pattern_en=1, color_in is ignored and the colour registers load 8 vertical bars, each H_ACTIVE/8 wide. Bar index b = 0..7 from left. Per channel, a bit is set in b (R=bit2, G=bit1, B=bit0); a set bit gives all-ones, a clear bit gives 0. Bars are computed from the delayed x, so they stay aligned at any LAT.
  - Not defined: the port is absent and colour always comes from color_in.

## Test plan
- Reset and cadence, small mode H=8/2/3/2, V=4/1/1/1, LAT=1, H_POL=V_POL=0.
  - Release rst_n: hsync period 15 clocks, low for 3 clocks starting 11 clocks after release.
  - Frame period 105 clocks. vsync low for 15 clocks.
  - de high for 32 clocks per frame.
- Latency, LAT=3, color_in = {next_x[3:0] delayed by 2 cycles, 0, 0}: every de=1 cycle shows red equal to the x of that output pixel; pixel (0,0) appears 3 clocks after release.
- Strobes, small mode: frame_start pulses once per 105 clocks; line_start pulses 4 times per frame, each 15 clocks apart; both fire together on pixel (0,0).
- Mid-frame reset: assert rst_n low at v_cnt=2, h_cnt=5.
  - Outputs immediately go to their reset values.
  - After release, the next frame_start comes LAT clocks after release.
- Polarity: with H_POL=1, V_POL=1, hsync and vsync are inverted relative to the first scenario, and de and colours are unchanged.
- With VGA_TIMING_TEST_PATTERN_EN defined, H_ACTIVE=16, pattern_en=1: output x=0..1 is black, x=2..3 is blue (B=all-ones), and x=14..15 is white.
